score_keeper: RTL and testbench

Downstream consumer of the monster/hero state machine's packed monster bus and `alive` flag. Detects monsters killed by the hero (slot valid bit falling while the game stays alive), queues the kills, and counts them one per cycle into a 4-digit BCD score. Also tracks the session best score and a difficulty level. Outputs feed the seven-segment/VGA score display and the `clk_move` rate selector.

---
 rtl/fury_pkg.sv | 30 +++
 rtl/bcd_counter4.sv | 55 +++++
 rtl/score_keeper.sv | 164 ++++++++++++++++
 tb/tb_score_keeper.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fury_pkg.sv
// ============================================================================
// Module   : fury_pkg
// Purpose  : Monster bus slot layout and score-keeper state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fury_pkg;

  localparam int MONSTERS  = 12;
  localparam int SLOT_W    = 19;
  localparam int MAX_LEVEL = 7;
  localparam int PEND_W    = 6;

  // Bit offsets of the fields inside one monster slot
  localparam int VALID  = 0;
  localparam int DIR_LO = 1;
  localparam int X_LO   = 3;
  localparam int Y_LO   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_counter4.sv
// ============================================================================
// Module   : bcd_counter4
// Purpose  : 4-digit BCD up-counter with clear, saturating at 9999.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o,
  output logic        ones_wrap_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        w_at_max;
  logic        w_carry;

  assign w_at_max = (count_q == 16'h9999);

  always_comb begin
    count_d = count_q;
    w_carry = inc_i & ~w_at_max;
    for (int k = 0; k < 4; k++) begin
      if (w_carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          count_d[4*k +: 4] = 4'd0;
        end else begin
          count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          w_carry           = 1'b0;
        end
      end
    end
    if (clr_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign ones_wrap_o = inc_i & ~clr_i & ~w_at_max & (count_q[3:0] == 4'd9);

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module   : score_keeper
// Purpose  : Counts hero kills from the monster bus into a BCD score, tracks
//            session best and difficulty level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
  parameter int MONSTERS  = fury_pkg::MONSTERS,
  parameter int SLOT_W    = fury_pkg::SLOT_W,
  parameter int MAX_LEVEL = fury_pkg::MAX_LEVEL,
  parameter int PEND_W    = fury_pkg::PEND_W
) (
  input  logic                       clk_game,
  input  logic                       rst,
  input  logic                       alive,
  input  logic [MONSTERS*SLOT_W-1:0] state_monsters,
  output logic [15:0]                score,
  output logic [15:0]                best,
  output logic [2:0]                 level,
  output logic                       game_over,
  output logic                       busy
);

  import fury_pkg::*;

  localparam int KW = $clog2(MONSTERS + 1);
  localparam int SW = PEND_W + KW;
  localparam logic [SW-1:0] PEND_MAX = SW'((1 << PEND_W) - 1);

  state_e              state_q;
  logic [MONSTERS-1:0] valid_q;
  logic                alive_q;
  logic [PEND_W-1:0]   pend_q;
  logic [PEND_W-1:0]   pend_d;
  logic [2:0]          level_q;
  logic [15:0]         best_q;
  logic                game_over_q;
  logic                start_pend_q;

  logic [MONSTERS-1:0] w_valid_cur;
  logic [MONSTERS-1:0] w_kill_vec;
  logic [KW-1:0]       w_kills;
  logic [SW-1:0]       w_pend_sum;
  logic                w_rise;
  logic                w_fall;
  logic                w_start;
  logic                w_counting;
  logic                w_ones_wrap;
  logic [15:0]         w_score;

  for (genvar i = 0; i < MONSTERS; i++) begin : g_slot
    assign w_valid_cur[i] = state_monsters[i*SLOT_W + VALID];
  end

  assign w_rise = alive & ~alive_q;
  assign w_fall = alive_q & ~alive;

  // Only falls seen while the game is running in both samples are kills
  assign w_kill_vec = valid_q & ~w_valid_cur
                    & {MONSTERS{alive_q & alive & (state_q == ST_PLAY)}};

  always_comb begin
    w_kills = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      w_kills = w_kills + KW'(w_kill_vec[i]);
    end
  end

  assign w_start    = (state_q == ST_IDLE) & alive & (w_rise | start_pend_q);
  assign w_counting = ((state_q == ST_PLAY) | (state_q == ST_DRAIN)) & (pend_q != '0);
  assign w_pend_sum = SW'(pend_q) + SW'(w_kills) - SW'(w_counting);

  always_comb begin
    pend_d = w_pend_sum[PEND_W-1:0];
    if (w_pend_sum > PEND_MAX) begin
      pend_d = PEND_MAX[PEND_W-1:0];
    end
    if (w_start) begin
      pend_d = '0;
    end
  end

  bcd_counter4 u_score (
    .clk        (clk_game),
    .rst        (rst),
    .clr_i      (w_start),
    .inc_i      (w_counting),
    .count_o    (w_score),
    .ones_wrap_o(w_ones_wrap)
  );

  always_ff @(posedge clk_game or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      alive_q      <= 1'b0;
      pend_q       <= '0;
      level_q      <= '0;
      best_q       <= '0;
      game_over_q  <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      valid_q <= w_valid_cur;
      alive_q <= alive;
      pend_q  <= pend_d;

      if (w_start) begin
        level_q <= '0;
      end else if (w_ones_wrap && (level_q < 3'(MAX_LEVEL))) begin
        level_q <= level_q + 3'd1;
      end

      case (state_q)
        ST_IDLE: begin
          game_over_q <= 1'b0;
          if (w_start) begin
            state_q      <= ST_PLAY;
            start_pend_q <= 1'b0;
          end else if (!alive) begin
            start_pend_q <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (w_fall) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_rise) begin
            start_pend_q <= 1'b1;
          end
          if (pend_q == '0) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
            if (w_score > best_q) begin
              best_q <= w_score;
            end
          end
        end
        ST_OVER: begin
          if (w_rise) begin
            start_pend_q <= 1'b1;
          end
          game_over_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign score     = w_score;
  assign best      = best_q;
  assign level     = level_q;
  assign game_over = game_over_q;
  assign busy      = (pend_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Directed self-checking bench for score_keeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

  localparam int NM = 12;
  localparam int SW = 19;

  logic             clk_game = 1'b0;
  logic             rst;
  logic             alive;
  logic [NM*SW-1:0] state_monsters;
  logic [15:0]      score;
  logic [15:0]      best;
  logic [2:0]       level;
  logic             game_over;
  logic             busy;

  int total = 0;
  int bad   = 0;

  score_keeper u_dut (
    .clk_game      (clk_game),
    .rst           (rst),
    .alive         (alive),
    .state_monsters(state_monsters),
    .score         (score),
    .best          (best),
    .level         (level),
    .game_over     (game_over),
    .busy          (busy)
  );

  always #5 clk_game = ~clk_game;

  task automatic tick();
    @(posedge clk_game);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Non-valid fields are filled with a busy pattern so only bit 0 may matter
  task automatic set_valid(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) begin
      state_monsters[i*SW +: SW] = {8'hA5, 8'h5A, 2'b11, v[i]};
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic kill_burst(input logic [NM-1:0] v);
    set_valid(v);
    tick();
    set_valid('0);
    tick();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
  endtask

  initial begin
    rst   = 1'b1;
    alive = 1'b0;
    set_valid('0);
    ticks(2);
    rst = 1'b0;
    tick();
    chk("rst_score", score, 16'h0000);
    chk("rst_best", best, 16'h0000);
    chk("rst_level", {13'd0, level}, 16'd0);
    chk("rst_gover", {15'd0, game_over}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);

    // Game 1: start with slot 0 valid, then kill it
    set_valid(12'h001);
    tick();
    alive = 1'b1;
    tick();
    set_valid('0);
    tick();
    chk("k1_busy", {15'd0, busy}, 16'd1);
    chk("k1_score_early", score, 16'h0000);
    tick();
    chk("k1_score", score, 16'h0001);
    chk("k1_busy_off", {15'd0, busy}, 16'd0);

    // Seven simultaneous kills count out one per cycle
    kill_burst(12'h07F);
    chk("k7_busy", {15'd0, busy}, 16'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("k7_score", score, 16'(1 + k));
      chk("k7_busy_step", {15'd0, busy}, (k < 7) ? 16'd1 : 16'd0);
    end

    kill_burst(12'h00F);
    ticks(4);
    chk("g1_score", score, 16'h0012);
    chk("g1_level", {13'd0, level}, 16'd1);

    // alive falls together with every valid bit: no kills, game ends
    set_valid(12'hFFF);
    tick();
    alive = 1'b0;
    set_valid('0);
    tick();
    chk("end1_busy", {15'd0, busy}, 16'd0);
    chk("end1_gover_pre", {15'd0, game_over}, 16'd0);
    tick();
    chk("end1_gover", {15'd0, game_over}, 16'd1);
    chk("end1_best", best, 16'h0012);
    chk("end1_score", score, 16'h0012);
    tick();
    chk("end1_gover_off", {15'd0, game_over}, 16'd0);

    // Game 2 ends lower: best must hold
    alive = 1'b1;
    tick();
    chk("g2_score_clr", score, 16'h0000);
    chk("g2_level_clr", {13'd0, level}, 16'd0);
    kill_burst(12'h01F);
    ticks(5);
    chk("g2_score", score, 16'h0005);
    alive = 1'b0;
    ticks(2);
    chk("end2_gover", {15'd0, game_over}, 16'd1);
    chk("end2_best", best, 16'h0012);
    tick();

    // Game 3: 75 kills saturate the level
    alive = 1'b1;
    tick();
    for (int r = 0; r < 6; r++) begin
      kill_burst(12'hFFF);
      ticks(4);
    end
    kill_burst(12'h007);
    wait_idle(200);
    chk("l75_busy", {15'd0, busy}, 16'd0);
    chk("l75_score", score, 16'h0075);
    chk("l75_level", {13'd0, level}, 16'd7);
    kill_burst(12'hFFF);
    wait_idle(100);
    chk("l87_score", score, 16'h0087);
    chk("l87_level", {13'd0, level}, 16'd7);

    // Keep pend saturated until the score pins at 9999
    for (int r = 0; r < 5000; r++) begin
      kill_burst(12'hFFF);
    end
    wait_idle(200);
    chk("sat_score", score, 16'h9999);
    chk("sat_busy", {15'd0, busy}, 16'd0);
    chk("sat_level", {13'd0, level}, 16'd7);
    kill_burst(12'h00F);
    wait_idle(20);
    chk("sat_score_hold", score, 16'h9999);
    chk("pre_rst_best", best, 16'h0012);

    // Asynchronous reset with pend=5 mid-game
    kill_burst(12'h01F);
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_score", score, 16'h0000);
    chk("arst_best", best, 16'h0000);
    chk("arst_level", {13'd0, level}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_gover", {15'd0, game_over}, 16'd0);
    tick();
    alive = 1'b0;
    rst   = 1'b0;
    tick();
    chk("post_rst_gover", {15'd0, game_over}, 16'd0);
    chk("post_rst_score", score, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
